// File: rtl/percept_serial_rx.sv
// Receive endpoint of the single-wire perceptron bus: deframes MSB-first bytes
// and decodes address/data packets, handing matched data bytes to the node.
module percept_serial_rx #(
  parameter logic [7:0] BCAST_ADDR = 8'hFF,
  parameter int         TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       serial_in,
  input  logic [7:0] address,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       addr_hit,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, BIT, STOP, RESYNC} bit_state_t;
  typedef enum logic       {ADDR, DATA} phase_t;

  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  bit_state_t  state;
  phase_t      phase;
  logic [2:0]  cnt;
  logic [7:0]  shreg;
  logic        match;
  logic [15:0] tcnt;

  logic start, byte_done, ferr, tmo, hit, bit_next_idle, phase_next_data;

  assign start     = (state == IDLE) && !serial_in;
  assign byte_done = (state == STOP) && serial_in;
  assign ferr      = (state == STOP) && !serial_in;
  assign hit       = (shreg == address) || (shreg == BCAST_ADDR);
  // A start bit on the expiry cycle wins, so tmo requires an idle-high line.
  assign tmo       = (TIMEOUT != 0) && (phase == DATA) && (state == IDLE) &&
                     serial_in && (tcnt == TLIM);

  // busy is registered from the state being entered at this edge
  assign bit_next_idle   = ((state == IDLE) && serial_in) || byte_done ||
                           ((state == RESYNC) && serial_in);
  assign phase_next_data = ((phase == ADDR) && byte_done) ||
                           ((phase == DATA) && !byte_done && !ferr && !tmo);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      phase      <= ADDR;
      cnt        <= '0;
      shreg      <= '0;
      match      <= 1'b0;
      tcnt       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_hit   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      addr_hit   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= !bit_next_idle || phase_next_data;

      case (state)
        IDLE: begin
          if (!serial_in) begin
            state <= BIT;
            cnt   <= 3'd7;
          end
        end
        BIT: begin
          shreg <= {shreg[6:0], serial_in};
          cnt   <= cnt - 3'd1;
          if (cnt == 3'd0) state <= STOP;
        end
        STOP: begin
          if (serial_in) begin
            state <= IDLE;
            if (phase == ADDR) begin
              match    <= hit;
              addr_hit <= hit;
              phase    <= DATA;
            end else begin
              if (match) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end
              phase <= ADDR;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= RESYNC;
            phase     <= ADDR;
            match     <= 1'b0;
          end
        end
        RESYNC: begin
          if (serial_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        tcnt <= '0;
      end else if ((TIMEOUT != 0) && (phase == DATA) && (state == IDLE)) begin
        if (tmo) begin
          phase <= ADDR;
          match <= 1'b0;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_percept_serial_rx.sv
// Directed bench for percept_serial_rx: expected data bytes are queued when a
// matched packet is sent and compared whenever data_valid pulses.
module tb_percept_serial_rx;

  logic       clk = 1'b0;
  logic       nRst;
  logic       serial_in;
  logic [7:0] address;
  logic [7:0] data_out;
  logic       data_valid, addr_hit, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int hits   = 0;
  int ferrs  = 0;
  logic [7:0] sb[$];
  logic dv_prev = 1'b0, ah_prev = 1'b0, fe_prev = 1'b0;

  percept_serial_rx #(.BCAST_ADDR(8'hFF), .TIMEOUT(64)) dut (
    .clk(clk), .nRst(nRst), .serial_in(serial_in), .address(address),
    .data_out(data_out), .data_valid(data_valid), .addr_hit(addr_hit),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic busy_ok);
    busy_ok = 1'b1;
    serial_in = 1'b0;
    tick();
    busy_ok &= busy;
    for (int i = 7; i >= 0; i--) begin
      serial_in = b[i];
      tick();
      busy_ok &= busy;
    end
    serial_in = 1'b1;
    tick();
  endtask

  // Output monitor: scoreboard pops and pulse-width checks
  always @(negedge clk) begin
    if (nRst) begin
      if (data_valid) begin
        if (sb.size() == 0) check("unexpected_data_valid", 32'd1, 32'd0);
        else check("data_out_sb", {24'd0, data_out}, {24'd0, sb.pop_front()});
        check("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
      end
      if (addr_hit) begin
        hits++;
        check("ah_single_cycle", {31'd0, ah_prev}, 32'd0);
      end
      if (frame_err) begin
        ferrs++;
        check("fe_single_cycle", {31'd0, fe_prev}, 32'd0);
      end
    end
    dv_prev = data_valid;
    ah_prev = addr_hit;
    fe_prev = frame_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bok;
    int   h0, f0;

    nRst = 1'b0;
    serial_in = 1'b1;
    address = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_addr_hit", {31'd0, addr_hit}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    nRst = 1'b1;
    tick();
    tick();

    // Address match, back-to-back frames
    h0 = hits;
    send_byte(8'h02, bok);
    check("match_addr_hit", {31'd0, addr_hit}, 32'd1);
    check("match_busy_mid", {31'd0, busy}, 32'd1);
    check("match_busy_frame1", {31'd0, bok}, 32'd1);
    sb.push_back(8'hA5);
    send_byte(8'hA5, bok);
    check("match_data_valid", {31'd0, data_valid}, 32'd1);
    check("match_data_out", {24'd0, data_out}, 32'hA5);
    check("match_busy_frame2", {31'd0, bok}, 32'd1);
    check("match_busy_end", {31'd0, busy}, 32'd0);
    tick();
    check("match_dv_drop", {31'd0, data_valid}, 32'd0);
    check("match_hits", 32'(hits - h0), 32'd1);

    // Address miss, then a matching packet
    h0 = hits;
    send_byte(8'h03, bok);
    send_byte(8'h5A, bok);
    tick();
    check("miss_data_out_held", {24'd0, data_out}, 32'hA5);
    check("miss_hits", 32'(hits - h0), 32'd0);
    sb.push_back(8'h11);
    send_byte(8'h02, bok);
    send_byte(8'h11, bok);
    tick();
    check("miss_then_match", {24'd0, data_out}, 32'h11);
    check("miss_then_hits", 32'(hits - h0), 32'd1);

    // Broadcast
    address = 8'h01;
    h0 = hits;
    sb.push_back(8'h3C);
    send_byte(8'hFF, bok);
    send_byte(8'h3C, bok);
    tick();
    check("bcast_data_out", {24'd0, data_out}, 32'h3C);
    check("bcast_hits", 32'(hits - h0), 32'd1);
    address = 8'h02;

    // Framing error: stop bit low, line low for 3 cycles
    h0 = hits;
    f0 = ferrs;
    send_byte(8'h02, bok);
    serial_in = 1'b0;
    tick();
    for (int i = 7; i >= 0; i--) begin
      serial_in = (i % 2 == 0);
      tick();
    end
    serial_in = 1'b0;
    tick();
    check("ferr_pulse", {31'd0, frame_err}, 32'd1);
    check("ferr_no_dv", {31'd0, data_valid}, 32'd0);
    tick();
    tick();
    check("ferr_resync_busy", {31'd0, busy}, 32'd1);
    serial_in = 1'b1;
    tick();
    check("ferr_no_start", {31'd0, busy}, 32'd0);
    sb.push_back(8'h44);
    send_byte(8'h02, bok);
    check("ferr_next_addr", {31'd0, addr_hit}, 32'd1);
    send_byte(8'h44, bok);
    tick();
    check("ferr_count", 32'(ferrs - f0), 32'd1);
    check("ferr_hits", 32'(hits - h0), 32'd2);

    // Timeout expires after 64 idle cycles
    h0 = hits;
    send_byte(8'h02, bok);
    repeat (64) tick();
    check("tmo64_busy", {31'd0, busy}, 32'd0);
    sb.push_back(8'h77);
    send_byte(8'h02, bok);
    check("tmo64_readdr", {31'd0, addr_hit}, 32'd1);
    send_byte(8'h77, bok);
    tick();
    check("tmo64_data_out", {24'd0, data_out}, 32'h77);
    check("tmo64_hits", 32'(hits - h0), 32'd2);

    // 63 idle cycles: start bit wins, second byte is data
    h0 = hits;
    send_byte(8'h02, bok);
    repeat (63) tick();
    check("tmo63_busy", {31'd0, busy}, 32'd1);
    sb.push_back(8'h02);
    send_byte(8'h02, bok);
    check("tmo63_dv", {31'd0, data_valid}, 32'd1);
    tick();
    check("tmo63_data_out", {24'd0, data_out}, 32'h02);
    check("tmo63_hits", 32'(hits - h0), 32'd1);

    // Reset during bit 4 of a data frame
    send_byte(8'h02, bok);
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1; tick();
    serial_in = 1'b1; tick();
    serial_in = 1'b0; tick();
    nRst = 1'b0;
    #1;
    check("midrst_data_out", {24'd0, data_out}, 32'h00);
    check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_addr_hit", {31'd0, addr_hit}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    serial_in = 1'b1;
    tick();
    nRst = 1'b1;
    tick();
    tick();
    check("postrst_idle", {31'd0, busy}, 32'd0);
    sb.push_back(8'h99);
    send_byte(8'h02, bok);
    check("postrst_addr_hit", {31'd0, addr_hit}, 32'd1);
    send_byte(8'h99, bok);
    tick();
    check("postrst_data_out", {24'd0, data_out}, 32'h99);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
